// File: rtl/vga_pkg.sv
// Shared VGA pipeline definitions: counter/colour widths, named colours and
// the timing bus that travels alongside every pixel.
package vga_pkg;

  localparam int unsigned HCNT_W = 11;
  localparam int unsigned VCNT_W = 10;
  localparam int unsigned RGB_W  = 12;

  localparam logic [RGB_W-1:0] WHITE = 12'hfff;
  localparam logic [RGB_W-1:0] BLACK = 12'h000;
  localparam logic [RGB_W-1:0] GREEN = 12'h0f0;

  typedef struct packed {
    logic [HCNT_W-1:0] hcount;
    logic [VCNT_W-1:0] vcount;
    logic              hsync;
    logic              vsync;
    logic              hblnk;
    logic              vblnk;
  } vga_timing_t;

endpackage

// File: rtl/sig_delay.sv
// Fixed-depth shift-register delay line with synchronous clear.
module sig_delay #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (i_clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_d;
      for (int unsigned i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/draw_image_overlay.sv
// Keys a ROM-resident bitmap over the video stream; position and mode
// controls are sampled once per frame on the vblank rising edge.
module draw_image_overlay
  import vga_pkg::*;
#(
  parameter int              IMG_W        = 512,
  parameter int              IMG_H        = 64,
  parameter int              SCALE        = 0,
  parameter int              ROM_LAT      = 1,
  parameter logic [11:0]     KEY_COLOR    = WHITE,
  parameter logic [11:0]     HL_COLOR     = GREEN,
  parameter int              BLINK_FRAMES = 16,
  parameter int              X_DEF        = 256,
  parameter int              Y_DEF        = 320,
  localparam int             XW           = $clog2(IMG_W),
  localparam int             YW           = $clog2(IMG_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              hblnk_in,
  input  logic              vblnk_in,
  input  logic [11:0]       rgb_in,
  input  logic [10:0]       xpos_in,
  input  logic [9:0]        ypos_in,
  input  logic              en_in,
  input  logic              hl_in,
  input  logic              blink_in,
  input  logic [11:0]       rgb_pixel,
  output logic [YW+XW-1:0]  pixel_addr,
  output logic [10:0]       hcount_out,
  output logic [9:0]        vcount_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              hblnk_out,
  output logic              vblnk_out,
  output logic [11:0]       rgb_out
);

  localparam int unsigned WIN_W = int'(IMG_W) << SCALE;
  localparam int unsigned WIN_H = int'(IMG_H) << SCALE;
  localparam int          CW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic          r_vblnk_prev;
  logic [10:0]   r_x_sh;
  logic [9:0]    r_y_sh;
  logic          r_en_sh, r_hl_sh, r_blink_sh;
  logic [CW-1:0] r_frame_cnt;
  logic          r_phase;

  logic w_vb_rise;
  assign w_vb_rise = vblnk_in & ~r_vblnk_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vblnk_prev <= 1'b0;
      r_x_sh       <= 11'(X_DEF);
      r_y_sh       <= 10'(Y_DEF);
      r_en_sh      <= 1'b1;
      r_hl_sh      <= 1'b0;
      r_blink_sh   <= 1'b0;
      r_frame_cnt  <= '0;
      r_phase      <= 1'b0;
    end else begin
      r_vblnk_prev <= vblnk_in;
      if (w_vb_rise) begin
        r_x_sh     <= xpos_in;
        r_y_sh     <= ypos_in;
        r_en_sh    <= en_in;
        r_hl_sh    <= hl_in;
        r_blink_sh <= blink_in;
        if (r_frame_cnt == CW'(BLINK_FRAMES - 1)) begin
          r_frame_cnt <= '0;
          r_phase     <= ~r_phase;
        end else begin
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end
      end
    end
  end

  // Left/above the origin the subtraction wraps large, so the range test clips.
  logic [11:0] w_dx;
  logic [10:0] w_dy;
  logic        w_in_win, w_vis0;
  assign w_dx     = {1'b0, hcount_in} - {1'b0, r_x_sh};
  assign w_dy     = {1'b0, vcount_in} - {1'b0, r_y_sh};
  assign w_in_win = (32'(w_dx) < WIN_W) && (32'(w_dy) < WIN_H) && !hblnk_in && !vblnk_in;
  assign w_vis0   = w_in_win & r_en_sh & ~(r_blink_sh & r_phase);

  assign pixel_addr = {w_dy[SCALE+YW-1 -: YW], w_dx[SCALE+XW-1 -: XW]};

  vga_timing_t w_t_in, w_t_d;
  assign w_t_in = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                    vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in};

  sig_delay #(.WIDTH($bits(vga_timing_t)), .DEPTH(ROM_LAT)) u_tdly (
    .clk(clk), .i_clr(rst), .i_d(w_t_in), .o_q(w_t_d)
  );

  // Visibility is folded to one bit before the delay; the shadows it reads
  // are the pre-update values, matching the un-delayed flag semantics.
  logic [11:0] w_rgb_d;
  logic        w_vis_d, w_hl_d;
  sig_delay #(.WIDTH(14), .DEPTH(ROM_LAT)) u_pdly (
    .clk(clk), .i_clr(rst), .i_d({rgb_in, w_vis0, r_hl_sh}),
    .o_q({w_rgb_d, w_vis_d, w_hl_d})
  );

  logic [11:0] w_rgb_mix;
  always_comb begin
    w_rgb_mix = w_rgb_d;
    if (w_vis_d) begin
      if (rgb_pixel != KEY_COLOR) w_rgb_mix = rgb_pixel;
      else if (w_hl_d)            w_rgb_mix = HL_COLOR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= w_t_d.hcount;
      vcount_out <= w_t_d.vcount;
      hsync_out  <= w_t_d.hsync;
      vsync_out  <= w_t_d.vsync;
      hblnk_out  <= w_t_d.hblnk;
      vblnk_out  <= w_t_d.vblnk;
      rgb_out    <= w_rgb_mix;
    end
  end

endmodule

// File: tb/tb_draw_image_overlay.sv
// Directed bench: three overlay instances (default, SCALE=1, ROM_LAT=3 with
// fast blink) share one stimulus stream, each with its own ROM model.
module tb_draw_image_overlay;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in;
  logic [10:0] xpos_in;
  logic [9:0]  ypos_in;
  logic        en_in, hl_in, blink_in;
  logic        force_key;

  always #5 clk = ~clk;

  logic [14:0] addr0, addr1, addr2;
  logic [11:0] pix0, pix1;
  logic [11:0] pix2_p [3];
  logic [10:0] hc0, hc1, hc2;
  logic [9:0]  vc0, vc1, vc2;
  logic        hs0, vs0, hb0, vb0, hs1, vs1, hb1, vb1, hs2, vs2, hb2, vb2;
  logic [11:0] rgb0, rgb1, rgb2;

  int checks = 0;
  int failures = 0;

  function automatic logic [11:0] rom_fn(input logic [14:0] a);
    return force_key ? 12'hfff : (a[11:0] ^ 12'h5a5);
  endfunction

  always @(posedge clk) begin
    pix0      <= rom_fn(addr0);
    pix1      <= rom_fn(addr1);
    pix2_p[0] <= rom_fn(addr2);
    pix2_p[1] <= pix2_p[0];
    pix2_p[2] <= pix2_p[1];
  end

  draw_image_overlay u0 (
    .clk(clk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos_in(xpos_in), .ypos_in(ypos_in), .en_in(en_in),
    .hl_in(hl_in), .blink_in(blink_in), .rgb_pixel(pix0), .pixel_addr(addr0),
    .hcount_out(hc0), .vcount_out(vc0), .hsync_out(hs0), .vsync_out(vs0),
    .hblnk_out(hb0), .vblnk_out(vb0), .rgb_out(rgb0)
  );

  draw_image_overlay #(.SCALE(1)) u1 (
    .clk(clk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos_in(xpos_in), .ypos_in(ypos_in), .en_in(en_in),
    .hl_in(hl_in), .blink_in(blink_in), .rgb_pixel(pix1), .pixel_addr(addr1),
    .hcount_out(hc1), .vcount_out(vc1), .hsync_out(hs1), .vsync_out(vs1),
    .hblnk_out(hb1), .vblnk_out(vb1), .rgb_out(rgb1)
  );

  draw_image_overlay #(.ROM_LAT(3), .BLINK_FRAMES(2)) u2 (
    .clk(clk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos_in(xpos_in), .ypos_in(ypos_in), .en_in(en_in),
    .hl_in(hl_in), .blink_in(blink_in), .rgb_pixel(pix2_p[2]), .pixel_addr(addr2),
    .hcount_out(hc2), .vcount_out(vc2), .hsync_out(hs2), .vsync_out(vs2),
    .hblnk_out(hb2), .vblnk_out(vb2), .rgb_out(rgb2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [10:0] h, input logic [9:0] v,
                       input logic hb, input logic vb, input logic [11:0] c);
    hcount_in = h; vcount_in = v; hblnk_in = hb; vblnk_in = vb; rgb_in = c;
    #1;
  endtask

  task automatic vblank_pulse();
    drive(11'd0, 10'd500, 1'b1, 1'b1, 12'h000);
    tick();
    drive(11'd0, 10'd501, 1'b1, 1'b0, 12'h000);
    tick();
  endtask

  logic [36:0] hist [10];
  logic [36:0] got_bus, exp_bus;
  logic [1:0]  kb;
  int          vis_tab [6] = '{1, 1, 0, 0, 1, 1};

  initial begin
    rst = 1'b1; force_key = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b0;
    xpos_in = 11'd256; ypos_in = 10'd320; en_in = 1'b1; hl_in = 1'b0; blink_in = 1'b0;
    drive(11'd5, 10'd5, 1'b0, 1'b0, 12'h123);
    tick(); tick();
    chk("reset_rgb0", 32'(rgb0), 32'h0);
    chk("reset_hsync0", 32'(hs0), 32'h0);
    chk("reset_hcount2", 32'(hc2), 32'h0);

    rst = 1'b0; hsync_in = 1'b0;
    tick();

    // Default window corners and right-edge miss
    drive(11'd256, 10'd320, 1'b0, 1'b0, 12'h123);
    chk("addr_origin", 32'(addr0), 32'h0);
    tick(); tick();
    chk("rgb_origin", 32'(rgb0), 32'h5a5);
    drive(11'd767, 10'd383, 1'b0, 1'b0, 12'h123);
    chk("addr_corner", 32'(addr0), 32'h7fff);
    tick(); tick();
    chk("rgb_corner", 32'(rgb0), 32'ha5a);
    drive(11'd768, 10'd383, 1'b0, 1'b0, 12'h123);
    tick(); tick();
    chk("rgb_right_miss", 32'(rgb0), 32'h123);

    // Key colour handling and highlight latching
    force_key = 1'b1;
    drive(11'd300, 10'd330, 1'b0, 1'b0, 12'h321);
    chk("addr_300_330", 32'(addr0), 32'h142c);
    tick(); tick();
    chk("key_no_hl", 32'(rgb0), 32'h321);
    hl_in = 1'b1;
    tick(); tick();
    chk("key_hl_unlatched", 32'(rgb0), 32'h321);
    vblank_pulse();
    drive(11'd300, 10'd330, 1'b0, 1'b0, 12'h321);
    tick(); tick();
    chk("key_hl_latched", 32'(rgb0), 32'h0f0);
    force_key = 1'b0;
    tick(); tick();
    chk("nonkey_with_hl", 32'(rgb0), 32'h189);

    // Mid-frame position change waits for the next vblank edge
    xpos_in = 11'd100;
    drive(11'd256, 10'd320, 1'b0, 1'b0, 12'h123);
    chk("xpos_not_yet", 32'(addr0), 32'h0);
    drive(11'd100, 10'd320, 1'b0, 1'b0, 12'h123);
    tick(); tick();
    chk("xpos_old_miss", 32'(rgb0), 32'h123);
    vblank_pulse();
    drive(11'd100, 10'd320, 1'b0, 1'b0, 12'h123);
    chk("xpos_new_addr", 32'(addr0), 32'h0);
    tick(); tick();
    chk("xpos_new_rgb", 32'(rgb0), 32'h5a5);

    // SCALE=1 instance at the origin
    xpos_in = 11'd0; ypos_in = 10'd0;
    vblank_pulse();
    drive(11'd0, 10'd0, 1'b0, 1'b0, 12'h123);
    chk("s1_h0", 32'(addr1), 32'h0);
    drive(11'd1, 10'd0, 1'b0, 1'b0, 12'h123);
    chk("s1_h1", 32'(addr1), 32'h0);
    drive(11'd2, 10'd2, 1'b0, 1'b0, 12'h123);
    chk("s1_h2_v2", 32'(addr1), 32'h201);
    drive(11'd1023, 10'd0, 1'b0, 1'b0, 12'h123);
    chk("s1_h1023", 32'(addr1), 32'h1ff);
    tick(); tick();
    chk("s1_rgb_h1023", 32'(rgb1), 32'h45a);
    drive(11'd5, 10'd128, 1'b0, 1'b0, 12'h456);
    tick(); tick();
    chk("s1_v128_miss", 32'(rgb1), 32'h456);

    // Mid-line reset, then exact 4-cycle latency on the ROM_LAT=3 instance
    drive(11'd400, 10'd330, 1'b0, 1'b0, 12'h777);
    hsync_in = 1'b1;
    rst = 1'b1;
    tick(); tick(); tick();
    chk("midrst_rgb2", 32'(rgb2), 32'h0);
    chk("midrst_timing2", 32'({hc2, vc2, hs2, vs2, hb2, vb2}), 32'h0);
    rst = 1'b0;
    xpos_in = 11'd256; ypos_in = 10'd320; hl_in = 1'b0; blink_in = 1'b1;
    for (int k = 0; k < 10; k++) begin
      kb = 2'(k);
      hsync_in = kb[0]; vsync_in = kb[1];
      drive(11'(k + 1), 10'd7, 1'b1, 1'b0, 12'(12'h100 + k));
      hist[k] = {rgb_in, hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};
      tick();
      got_bus = {rgb2, hc2, vc2, hs2, vs2, hb2, vb2};
      exp_bus = (k < 3) ? 37'd0 : hist[k-3];
      chk($sformatf("lat_timing_%0d", k), 32'(got_bus[24:0]), 32'(exp_bus[24:0]));
      chk($sformatf("lat_rgb_%0d", k), 32'(got_bus[36:25]), 32'(exp_bus[36:25]));
    end
    hsync_in = 1'b0; vsync_in = 1'b0;

    // Blink: frame 0 is the post-reset frame, then one vblank edge per frame
    for (int f = 0; f < 6; f++) begin
      if (f > 0) vblank_pulse();
      drive(11'd256, 10'd320, 1'b0, 1'b0, 12'h123);
      tick(); tick(); tick(); tick(); tick();
      chk($sformatf("blink_frame_%0d", f), 32'(rgb2), (vis_tab[f] != 0) ? 32'h5a5 : 32'h123);
    end
    en_in = 1'b0;
    for (int f = 0; f < 2; f++) begin
      vblank_pulse();
      drive(11'd256, 10'd320, 1'b0, 1'b0, 12'h2b2);
      tick(); tick(); tick(); tick(); tick();
      chk($sformatf("en0_frame_%0d", f), 32'(rgb2), 32'h2b2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/draw_image_overlay.md
# draw_image_overlay

Parametrised image-overlay stage for the VGA pixel pipeline. It reads a rectangular bitmap from an external synchronous ROM and keys it over the incoming video stream. Position, visibility, highlight and blink are runtime-controlled and are latched once per frame. It sits between the background/menu drawers and the output register stage. It can be instantiated several times in series, one instance per menu item or sprite.

## Interface
Parameters:
- IMG_W, 512: image width in source pixels. Must be a power of two.
- IMG_H, 64: image height in source pixels. Must be a power of two.
- SCALE, 0: integer zoom as a shift. Each source pixel covers 2^SCALE × 2^SCALE screen pixels. Legal values 0..2.
- ROM_LAT, 1: ROM read latency in clocks, from pixel_addr to rgb_pixel. Legal values 1..4.
- KEY_COLOR, 12'hfff: transparent colour.
- HL_COLOR, 12'h0f0: fill used for keyed pixels while highlight is active.
- BLINK_FRAMES, 16: frames per blink half-period. Must be ≥ 1.
- X_DEF, 256: X position loaded on reset.
- Y_DEF, 320: Y position loaded on reset.
- XW = log2(IMG_W), YW = log2(IMG_H): derived, not overridable.

Ports:
- clk, in, 1: pixel clock.
- rst, in, 1: synchronous reset, active-high.
- hcount_in, in, 11: horizontal pixel counter.
- vcount_in, in, 10: vertical line counter.
- hsync_in, vsync_in, hblnk_in, vblnk_in, in, 1 each: timing signals.
- rgb_in, in, 12: upstream pixel colour.
- xpos_in, in, 11: requested image left edge.
- ypos_in, in, 10: requested image top edge.
- en_in, in, 1: image visible.
- hl_in, in, 1: highlight mode.
- blink_in, in, 1: blink mode.
- rgb_pixel, in, 12: ROM data.
- pixel_addr, out, YW+XW: ROM address, {row, col}.
- hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, out: timing signals delayed by L.
- rgb_out, out, 12: composited colour.

## Operation
- **Frame latch.**
  - A vblnk rising edge is detected by comparing vblnk_in with its value registered one clock earlier.
  - On that edge cycle, xpos_in, ypos_in, en_in, hl_in and blink_in are copied into shadow registers.
  - Changes at any other time take effect only at the next vblnk rising edge.
- **Blink counter.**
  - A frame counter increments on every vblnk rising edge and wraps at BLINK_FRAMES-1.
  - A phase bit toggles on each wrap.
  - When the blink shadow is set, the image is suppressed while phase=1.
  - When the blink shadow is clear, the counter and phase keep running but are ignored.
- **Window test, cycle 0, combinational from the inputs.**
  - dx = hcount_in - x_sh, computed in 12 bits. dy = vcount_in - y_sh, computed in 11 bits.
  - in_win is true when all of the following hold: dx < IMG_W<<SCALE (unsigned); dy < IMG_H<<SCALE (unsigned); hblnk_in=0; vblnk_in=0.
  - If the counter is to the left of or above the origin, the subtraction wraps to a large value, which fails the test. This gives implicit clipping.
  - A window that extends past the visible area is clipped by the blanking signals.
- **Address.** pixel_addr = {dy[SCALE+YW-1:SCALE], dx[SCALE+XW-1:SCALE]}. It is driven combinationally from the inputs and is don't-care when in_win=0.
- **Composite, using in_win and the shadow flags delayed by ROM_LAT and aligned with rgb_pixel.**
  - vis = in_win & en_sh & ~(blink_sh & phase).
  - If vis=0: rgb_in passes through.
  - If vis=1 and rgb_pixel≠KEY_COLOR: rgb_pixel.
  - If vis=1, rgb_pixel=KEY_COLOR and hl_sh=1: HL_COLOR.
  - Otherwise: rgb_in.
- **Reset values.**
  - All outputs are 0.
  - The delay line is cleared.
  - x_sh=X_DEF, y_sh=Y_DEF, en_sh=1, hl_sh=0, blink_sh=0.
  - Frame counter=0, phase=0.
  - The stored previous vblnk is 0, so if vblnk_in is high on the first cycle after reset, that cycle is treated as a rising edge.
  - If reset is asserted mid-frame, the pipeline flushes. Normal output resumes L cycles after release. The shadow registers keep their defaults until the next vblnk rising edge.

## Timing
- Latency L = ROM_LAT+1 for all outputs, relative to the inputs.
  - rgb_in, the timing signals and the cycle-0 flags pass through a ROM_LAT-deep delay line.
  - The composite result and the delayed timing signals are then registered once.
- Throughput is one pixel per clock. There is no stall.
- On the cycle of a vblnk rising edge, the shadow registers update on that clock edge. Pixels on the same cycle are blanked, so they are unaffected.

## Structure
- The shared package/header `vga_pkg` holds: counter widths (11/10), colour width 12, and the named colours WHITE, BLACK and GREEN.
- One sub-module, `sig_delay`, is a parametrised delay line with WIDTH and DEPTH parameters and a synchronous clear. It is used for the timing bus and for {rgb_in, in_win, flags}.

## Test plan
- Defaults (512×64 at 256,320), ROM_LAT=1, ROM pattern = address: hcount 256, vcount 320 → pixel_addr=0. At hcount 767, vcount 383 → 0x7FFF. rgb_out equals the ROM data 2 cycles later. At hcount 768 → rgb_in passes through.
- Pixel = 12'hfff inside the window with hl=0 → rgb_in. With hl=1 latched → 12'h0f0. A non-key pixel is unaffected by hl.
- Change xpos_in to 100 mid-frame → the window stays at 256 until the vblnk rising edge. From the next frame, hcount 100 → pixel_addr column 0.
- SCALE=1, xpos=0, ypos=0: hcount 0 and 1 both map to column 0. hcount 1023 maps to column 511, row 0 on line 0. vcount 128 is outside the window.
- blink=1, BLINK_FRAMES=2: the image is visible for 2 frames, hidden for 2, visible for 2. en=0 → pure passthrough on every frame.
- rst pulsed mid-line, then ROM_LAT=3 sweep: outputs are 0 during reset. The first valid output appears 4 cycles after release. Timing outputs equal the inputs delayed by exactly 4 cycles.
